// File: rtl/oaram_compressor.sv
// oaram_compressor
// Drains the banked post-accumulation output buffer once a channel group has
// finished, quantises each element (ReLU, arithmetic right shift, saturation to
// the selected bitwidth) and writes zero-run-length encoded activations into
// the output activation RAM.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start                   begins a drain when idle
//   bitwidth, shift         quantisation mode and shift, captured at start
//   buffer_bank_read/entry  output-buffer read address (from registered idx)
//   buffer_data_read        buffer data, valid one cycle after the address
//   oaram_value/indices_value/address/write_enable, oaram_ready
//                           OARAM write port with ready/valid handshake
//   busy, done, overflow    status; overflow is sticky until the next start
//   entry_count             number of entries written by the current/last drain
//
// State | Meaning
// IDLE  | waiting for start
// READ  | buffer address for idx presented
// PROC  | buffer data valid; quantise and decide whether to emit
// WRITE | OARAM write pending until oaram_ready
// DONE  | one-cycle done pulse

module oaram_compressor #(
    parameter int RAM_WIDTH   = 10,
    parameter int BANK_COUNT  = 32,
    parameter int ENTRY_DEPTH = 4,
    parameter int INDEX_WIDTH = 4,
    parameter int ACC_WIDTH   = 24
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [1:0]                     bitwidth,
    input  logic [4:0]                     shift,
    output logic [$clog2(BANK_COUNT)-1:0]  buffer_bank_read,
    output logic [$clog2(ENTRY_DEPTH)-1:0] buffer_bank_entry,
    input  logic [ACC_WIDTH-1:0]           buffer_data_read,
    output logic [7:0]                     oaram_value,
    output logic [INDEX_WIDTH-1:0]         oaram_indices_value,
    output logic [RAM_WIDTH-1:0]           oaram_address,
    output logic                           oaram_write_enable,
    input  logic                           oaram_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic [RAM_WIDTH:0]             entry_count
);

    localparam int N       = BANK_COUNT * ENTRY_DEPTH;
    localparam int IDX_W   = $clog2(N);
    localparam int BANK_W  = $clog2(BANK_COUNT);
    localparam int ENTRY_W = $clog2(ENTRY_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_PROC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [INDEX_WIDTH-1:0] run_q, run_d;
    logic [1:0]             bw_q, bw_d;
    logic [4:0]             shift_q, shift_d;
    logic [7:0]             value_q, value_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [RAM_WIDTH-1:0]   addr_q, addr_d;
    logic                   we_q, we_d;
    logic                   ovf_q, ovf_d;
    logic [RAM_WIDTH:0]     cnt_q, cnt_d;

    logic [31:0]            idx_ext;
    logic                   idx_last;
    logic [ACC_WIDTH-1:0]   relu_shr;
    logic [7:0]             maxq;
    logic [7:0]             q;

    assign idx_ext           = 32'(idx_q);
    assign buffer_bank_read  = BANK_W'(idx_ext % 32'(BANK_COUNT));
    assign buffer_bank_entry = ENTRY_W'(idx_ext / 32'(BANK_COUNT));
    assign idx_last          = (idx_q == IDX_W'(N - 1));

    // Negative data clamps to zero, so a logical shift of the surviving
    // non-negative value is identical to the arithmetic shift.
    always_comb begin
        relu_shr = '0;
        if (!buffer_data_read[ACC_WIDTH-1]) begin
            relu_shr = buffer_data_read >> shift_q;
        end
        case (bw_q)
            2'b00:   maxq = 8'd3;
            2'b01:   maxq = 8'd15;
            default: maxq = 8'd255;
        endcase
        if (relu_shr > {{(ACC_WIDTH-8){1'b0}}, maxq}) begin
            q = maxq;
        end else begin
            q = relu_shr[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = run_q;
        bw_d    = bw_q;
        shift_d = shift_q;
        value_d = value_q;
        index_d = index_q;
        addr_d  = addr_q;
        we_d    = we_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bw_d    = bitwidth;
                    shift_d = shift;
                    idx_d   = '0;
                    run_d   = '0;
                    addr_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_PROC;
            end
            S_PROC: begin
                if (q != 8'd0) begin
                    value_d = q;
                    index_d = run_q;
                    we_d    = 1'b1;
                    run_d   = '0;
                    state_d = S_WRITE;
                end else if (run_q == {INDEX_WIDTH{1'b1}}) begin
                    // Saturated run: emit a zero-valued entry carrying MAXRUN.
                    value_d = 8'd0;
                    index_d = run_q;
                    we_d    = 1'b1;
                    run_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    run_d = run_q + 1'b1;
                    if (idx_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (oaram_ready) begin
                    we_d  = 1'b0;
                    cnt_d = cnt_q + 1'b1;
                    if (addr_q == {RAM_WIDTH{1'b1}}) begin
                        // RAM full: stop without wrapping the address.
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (idx_last) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            run_q   <= '0;
            bw_q    <= '0;
            shift_q <= '0;
            value_q <= '0;
            index_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            bw_q    <= bw_d;
            shift_q <= shift_d;
            value_q <= value_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oaram_value         = value_q;
    assign oaram_indices_value = index_q;
    assign oaram_address       = addr_q;
    assign oaram_write_enable  = we_q;
    assign overflow            = ovf_q;
    assign entry_count         = cnt_q;
    assign busy                = (state_q != S_IDLE);
    assign done                = (state_q == S_DONE);

endmodule

// File: tb/tb_oaram_compressor.sv
// Testbench for oaram_compressor: a default-sized instance (A) driven from a
// table of directed vectors plus stall/reset sequences, and a small instance
// (B: 4-entry RAM, 8-element scan) for the overflow cases.

module tb_oaram_compressor;
    localparam int N  = 128;
    localparam int NB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start_a, start_b, oaram_ready;
    logic [1:0]  bitwidth;
    logic [4:0]  shift;

    logic [4:0]  bank_a;
    logic [1:0]  entry_a;
    logic [23:0] data_a;
    logic [7:0]  val_a;
    logic [3:0]  ix_a;
    logic [9:0]  addr_a;
    logic        we_a, busy_a, done_a, ovf_a;
    logic [10:0] cnt_a;

    logic [1:0]  bank_b;
    logic        entry_b;
    logic [23:0] data_b;
    logic [7:0]  val_b;
    logic [3:0]  ix_b;
    logic [1:0]  addr_b;
    logic        we_b, busy_b, done_b, ovf_b;
    logic [2:0]  cnt_b;

    logic [23:0] mem [0:N-1];

    oaram_compressor dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .bitwidth(bitwidth), .shift(shift),
        .buffer_bank_read(bank_a), .buffer_bank_entry(entry_a),
        .buffer_data_read(data_a),
        .oaram_value(val_a), .oaram_indices_value(ix_a),
        .oaram_address(addr_a), .oaram_write_enable(we_a),
        .oaram_ready(oaram_ready),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .entry_count(cnt_a)
    );

    oaram_compressor #(.RAM_WIDTH(2), .BANK_COUNT(4), .ENTRY_DEPTH(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .bitwidth(bitwidth), .shift(shift),
        .buffer_bank_read(bank_b), .buffer_bank_entry(entry_b),
        .buffer_data_read(data_b),
        .oaram_value(val_b), .oaram_indices_value(ix_b),
        .oaram_address(addr_b), .oaram_write_enable(we_b),
        .oaram_ready(oaram_ready),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .entry_count(cnt_b)
    );

    // Buffer model: one-cycle read latency.
    always @(posedge clk) begin
        data_a <= mem[{entry_a, bank_a}];
        data_b <= mem[{entry_b, bank_b}];
    end

    int cyc = 0;
    int last_acc_a = 0;
    int viol = 0;
    int max_idx_b = 0;
    logic [21:0] wq_a [$];
    logic [21:0] wq_b [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we_a && oaram_ready) begin
            wq_a.push_back({val_a, ix_a, addr_a});
            last_acc_a <= cyc;
        end
        if (we_b && oaram_ready) wq_b.push_back({val_b, ix_b, 8'd0, addr_b});
        if (((done_a || ovf_a) && we_a) || ((done_b || ovf_b) && we_b)) viol <= viol + 1;
        if (start_b) max_idx_b <= 0;
        else if (busy_b && int'({entry_b, bank_b}) > max_idx_b) max_idx_b <= int'({entry_b, bank_b});
    end

    typedef struct {
        logic [1:0]        bw;
        logic [4:0]        sh;
        int                nz;
        logic [2:0][6:0]   nidx;
        logic [2:0][23:0]  ndata;
        int                nw;
        logic [11:0][11:0] w;      // {value, index}; address = position
        bit                lat;    // last element is emitted: check done latency
    } vec_t;

    vec_t tbl [8];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic vinit(input int i, input logic [1:0] bw, input logic [4:0] sh, input bit lat);
        tbl[i].bw = bw; tbl[i].sh = sh; tbl[i].lat = lat;
        tbl[i].nz = 0; tbl[i].nw = 0; tbl[i].nidx = '0; tbl[i].ndata = '0; tbl[i].w = '0;
    endtask

    task automatic add_nz(input int i, input int idx, input logic [23:0] d);
        tbl[i].nidx[tbl[i].nz]  = 7'(idx);
        tbl[i].ndata[tbl[i].nz] = d;
        tbl[i].nz++;
    endtask

    task automatic add_w(input int i, input logic [7:0] v, input logic [3:0] ix);
        tbl[i].w[tbl[i].nw] = {v, ix};
        tbl[i].nw++;
    endtask

    task automatic add_ph(input int i, input int n);
        for (int k = 0; k < n; k++) add_w(i, 8'd0, 4'd15);
    endtask

    task automatic setup_mem(input int v);
        for (int j = 0; j < N; j++) mem[j] = '0;
        for (int k = 0; k < tbl[v].nz; k++) mem[tbl[v].nidx[k]] = tbl[v].ndata[k];
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while (!done_a && n < 3000) begin @(negedge clk); n++; end
        chk(name, 32'(done_a), 32'd1);
    endtask

    task automatic wait_done_b(input string name);
        int n = 0;
        while (!done_b && n < 500) begin @(negedge clk); n++; end
        chk(name, 32'(done_b), 32'd1);
    endtask

    task automatic run_vec(input int v);
        int base;
        setup_mem(v);
        oaram_ready = 1'b1;
        @(negedge clk);
        base = wq_a.size();
        bitwidth = tbl[v].bw; shift = tbl[v].sh; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a($sformatf("v%0d_done", v));
        chk($sformatf("v%0d_nwrites", v), 32'(wq_a.size() - base), 32'(tbl[v].nw));
        for (int k = 0; k < tbl[v].nw; k++)
            if (base + k < wq_a.size())
                chk($sformatf("v%0d_w%0d", v, k), 32'(wq_a[base + k]), 32'({tbl[v].w[k], 10'(k)}));
        chk($sformatf("v%0d_entry_count", v), 32'(cnt_a), 32'(tbl[v].nw));
        chk($sformatf("v%0d_overflow", v), 32'(ovf_a), 32'd0);
        if (tbl[v].lat) chk($sformatf("v%0d_done_latency", v), 32'(cyc - last_acc_a), 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d_idle_after", v), 32'({busy_a, done_a}), 32'd0);
    endtask

    task automatic start_b_pulse();
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;

        vinit(0, 2'b10, 5'd0, 1'b0);
        add_nz(0, 0, 24'd100); add_nz(0, 5, 24'd7);
        add_w(0, 8'd100, 4'd0); add_w(0, 8'd7, 4'd4); add_ph(0, 7);

        vinit(1, 2'b01, 5'd2, 1'b0);
        add_nz(1, 0, -24'sd50); add_nz(1, 1, 24'd1000); add_nz(1, 2, 24'd20);
        add_w(1, 8'd15, 4'd1); add_w(1, 8'd5, 4'd0); add_ph(1, 7);

        vinit(2, 2'b00, 5'd0, 1'b1);
        add_nz(2, 3, 24'd2); add_nz(2, 4, 24'd9); add_nz(2, 127, 24'd300);
        add_w(2, 8'd2, 4'd3); add_w(2, 8'd3, 4'd0); add_ph(2, 7); add_w(2, 8'd3, 4'd10);

        vinit(3, 2'b10, 5'd4, 1'b0);
        add_nz(3, 10, 24'd100000); add_nz(3, 11, 24'hFFFFFF); add_nz(3, 12, 24'd31);
        add_w(3, 8'd255, 4'd10); add_w(3, 8'd1, 4'd1); add_ph(3, 7);

        vinit(4, 2'b11, 5'd0, 1'b1);
        add_nz(4, 120, 24'd300); add_nz(4, 121, 24'd16); add_nz(4, 127, 24'd5);
        add_ph(4, 7); add_w(4, 8'd255, 4'd8); add_w(4, 8'd16, 4'd0); add_w(4, 8'd5, 4'd5);

        vinit(5, 2'b00, 5'd22, 1'b0);
        add_nz(5, 0, 24'h7FFFFF);
        add_w(5, 8'd1, 4'd0); add_ph(5, 7);

        vinit(6, 2'b10, 5'd0, 1'b1);
        add_ph(6, 8);

        vinit(7, 2'b01, 5'd0, 1'b0);
        add_nz(7, 125, 24'd15); add_nz(7, 126, 24'd16); add_nz(7, 127, 24'h800000);
        add_ph(7, 7); add_w(7, 8'd15, 4'd13); add_w(7, 8'd15, 4'd0);

        for (int j = 0; j < N; j++) mem[j] = '0;
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; oaram_ready = 1'b1;
        bitwidth = 2'b00; shift = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset_a_outputs", 32'({val_a, ix_a, addr_a, we_a, busy_a, done_a, ovf_a, cnt_a}), 32'd0);
        chk("reset_a_scanaddr", 32'({entry_a, bank_a}), 32'd0);
        chk("reset_b_outputs", 32'({val_b, ix_b, addr_b, we_b, busy_b, done_b, ovf_b, cnt_b}), 32'd0);
        reset_n = 1'b1;

        for (int v = 0; v < 8; v++) run_vec(v);

        // Back-pressure: first write held for 5 cycles, stray start ignored.
        setup_mem(0);
        oaram_ready = 1'b0;
        @(negedge clk);
        base = wq_a.size();
        bitwidth = 2'b10; shift = 5'd0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!we_a && n < 20) begin @(negedge clk); n++; end
        chk("stall_we_rise", 32'(we_a), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall_hold%0d", c), 32'({we_a, val_a, ix_a, addr_a}),
                32'({1'b1, 8'd100, 4'd0, 10'd0}));
            if (c == 2) start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        chk("stall_no_accept", 32'(wq_a.size() - base), 32'd0);
        oaram_ready = 1'b1;
        @(negedge clk);
        chk("stall_one_accept", 32'(wq_a.size() - base), 32'd1);
        chk("stall_addr_adv", 32'({we_a, addr_a}), 32'({1'b0, 10'd1}));
        wait_done_a("stall_done");
        chk("stall_nwrites", 32'(wq_a.size() - base), 32'd9);
        chk("stall_entry_count", 32'(cnt_a), 32'd9);
        chk("stall_first_write", 32'(wq_a[base]), 32'({8'd100, 4'd0, 10'd0}));
        @(negedge clk);

        // Reset while a write is pending, then a clean re-drain.
        setup_mem(0);
        oaram_ready = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!we_a && n < 20) begin @(negedge clk); n++; end
        chk("rst_we_pending", 32'(we_a), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_write", 32'({we_a, busy_a, done_a, ovf_a, addr_a, cnt_a, val_a, ix_a}), 32'd0);
        reset_n = 1'b1;
        run_vec(0);

        // Small instance: overflow mid-scan; remaining elements not read.
        for (int j = 0; j < N; j++) mem[j] = (j < NB) ? 24'd1 : 24'd0;
        bitwidth = 2'b00; shift = 5'd0; oaram_ready = 1'b1;
        base = wq_b.size();
        start_b_pulse();
        wait_done_b("ovf1_done");
        chk("ovf1_overflow", 32'(ovf_b), 32'd1);
        chk("ovf1_entry_count", 32'(cnt_b), 32'd4);
        chk("ovf1_nwrites", 32'(wq_b.size() - base), 32'd4);
        for (int k = 0; k < 4; k++)
            if (base + k < wq_b.size())
                chk($sformatf("ovf1_w%0d", k), 32'(wq_b[base + k]), 32'({8'd1, 4'd0, 10'(k)}));
        chk("ovf1_max_idx_read", 32'(max_idx_b), 32'd3);
        @(negedge clk);
        chk("ovf1_sticky", 32'({busy_b, ovf_b}), 32'({1'b0, 1'b1}));

        // Overflow on the very last element; start clears the sticky flag.
        for (int j = 0; j < NB; j++) mem[j] = (j >= 4) ? 24'd1 : 24'd0;
        base = wq_b.size();
        start_b_pulse();
        chk("ovf2_cleared_by_start", 32'({busy_b, ovf_b}), 32'({1'b1, 1'b0}));
        wait_done_b("ovf2_done");
        chk("ovf2_overflow", 32'(ovf_b), 32'd1);
        chk("ovf2_entry_count", 32'(cnt_b), 32'd4);
        chk("ovf2_nwrites", 32'(wq_b.size() - base), 32'd4);
        if (base < wq_b.size()) chk("ovf2_w0", 32'(wq_b[base]), 32'({8'd1, 4'd4, 10'd0}));
        if (base + 3 < wq_b.size()) chk("ovf2_w3", 32'(wq_b[base + 3]), 32'({8'd1, 4'd0, 10'd3}));
        chk("ovf2_max_idx_read", 32'(max_idx_b), 32'd7);
        @(negedge clk);

        // Short all-zero scan: trailing run below MAXRUN is dropped.
        for (int j = 0; j < NB; j++) mem[j] = '0;
        base = wq_b.size();
        start_b_pulse();
        wait_done_b("zero_b_done");
        chk("zero_b_nwrites", 32'(wq_b.size() - base), 32'd0);
        chk("zero_b_count_ovf", 32'({cnt_b, ovf_b}), 32'd0);
        @(negedge clk);

        chk("done_ovf_vs_we_overlap", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
